// File: rtl/gray_rx_decoder.sv
// Receive-side gray decoder: synchronises an async gray word, decodes it to binary
// and classifies each sampled transition as hold / step up / step down / illegal.
module gray_rx_decoder #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clr,
  input  logic [WIDTH-1:0]     g_in,
  output logic [WIDTH-1:0]     bin_out,
  output logic                 out_valid,
  output logic                 step_up,
  output logic                 step_dn,
  output logic                 hold,
  output logic                 err,
  output logic                 fault,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {S_INIT, S_TRACK, S_FAULT} state_t;

  state_t r_state, w_state_nxt;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]     w_gs, w_bin, w_diff, w_inc;
  logic                 w_one_bit, w_multi_bit;

  logic [WIDTH-1:0]     r_prev_gray, r_prev_bin, r_bin_out;
  logic                 r_valid, r_up, r_dn, r_hold, r_err, r_fault;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  logic [WIDTH-1:0]     w_prev_gray_nxt, w_prev_bin_nxt, w_bin_out_nxt;
  logic                 w_valid_nxt, w_up_nxt, w_dn_nxt, w_hold_nxt, w_err_nxt, w_fault_nxt;
  logic [ERR_CNT_W-1:0] w_err_cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], g_in};
  end

  assign w_gs = r_sync[SYNC_STAGES-1];

  // Each binary bit is the XOR of all gray bits at or above it.
  for (genvar i = 0; i < WIDTH; i++) begin : g_dec
    assign w_bin[i] = ^w_gs[WIDTH-1:i];
  end

  assign w_diff      = w_gs ^ r_prev_gray;
  assign w_one_bit   = (w_diff != '0) && ((w_diff & (w_diff - WIDTH'(1))) == '0);
  assign w_multi_bit = (w_diff != '0) && !w_one_bit;
  assign w_inc       = r_prev_bin + WIDTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_INIT;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clr) begin
      w_state_nxt = S_INIT;
    end else if (en) begin
      case (r_state)
        S_INIT:  w_state_nxt = S_TRACK;
        S_TRACK: if (w_multi_bit) w_state_nxt = S_FAULT;
        S_FAULT: w_state_nxt = S_FAULT;
        default: w_state_nxt = S_INIT;
      endcase
    end
  end

  always_comb begin
    w_prev_gray_nxt = r_prev_gray;
    w_prev_bin_nxt  = r_prev_bin;
    w_bin_out_nxt   = r_bin_out;
    w_valid_nxt     = r_valid;
    w_up_nxt        = 1'b0;
    w_dn_nxt        = 1'b0;
    w_hold_nxt      = 1'b0;
    w_err_nxt       = 1'b0;
    w_fault_nxt     = r_fault;
    w_err_cnt_nxt   = r_err_cnt;
    if (clr) begin
      w_valid_nxt   = 1'b0;
      w_fault_nxt   = 1'b0;
      w_err_cnt_nxt = '0;
    end else if (en) begin
      case (r_state)
        S_INIT: begin
          w_prev_gray_nxt = w_gs;
          w_prev_bin_nxt  = w_bin;
          w_bin_out_nxt   = w_bin;
          w_valid_nxt     = 1'b1;
        end
        S_TRACK: begin
          if (w_diff == '0) begin
            w_hold_nxt = 1'b1;
          end else if (w_one_bit) begin
            w_up_nxt        = (w_bin == w_inc);
            w_dn_nxt        = (w_bin != w_inc);
            w_prev_gray_nxt = w_gs;
            w_prev_bin_nxt  = w_bin;
            w_bin_out_nxt   = w_bin;
          end else begin
            // Illegal change: keep the last good value, latch the fault.
            w_err_nxt     = 1'b1;
            w_fault_nxt   = 1'b1;
            w_err_cnt_nxt = (r_err_cnt == {ERR_CNT_W{1'b1}}) ? r_err_cnt
                                                              : r_err_cnt + ERR_CNT_W'(1);
          end
        end
        S_FAULT: w_fault_nxt = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_gray <= '0;
      r_prev_bin  <= '0;
      r_bin_out   <= '0;
      r_valid     <= 1'b0;
      r_up        <= 1'b0;
      r_dn        <= 1'b0;
      r_hold      <= 1'b0;
      r_err       <= 1'b0;
      r_fault     <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_prev_gray <= w_prev_gray_nxt;
      r_prev_bin  <= w_prev_bin_nxt;
      r_bin_out   <= w_bin_out_nxt;
      r_valid     <= w_valid_nxt;
      r_up        <= w_up_nxt;
      r_dn        <= w_dn_nxt;
      r_hold      <= w_hold_nxt;
      r_err       <= w_err_nxt;
      r_fault     <= w_fault_nxt;
      r_err_cnt   <= w_err_cnt_nxt;
    end
  end

  assign bin_out   = r_bin_out;
  assign out_valid = r_valid;
  assign step_up   = r_up;
  assign step_dn   = r_dn;
  assign hold      = r_hold;
  assign err       = r_err;
  assign fault     = r_fault;
  assign err_cnt   = r_err_cnt;

endmodule
